// File: rtl/dmem_responder.sv
// Data-memory responder: a single-outstanding load/store port with a fixed
// number of wait states, byte/half/word lanes and error reporting.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWData,
    input  logic [2:0]  iFunct3,
    output logic [31:0] oRData,
    output logic        oReady,
    output logic        oStall,
    output logic        oErr
);

    localparam int unsigned AddrW = $clog2(DEPTH_WORDS);
    // WAIT_CYCLES-1 would underflow when no wait states are configured.
    localparam logic [3:0] WaitLoad = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [2:0] F3B  = 3'b000;
    localparam logic [2:0] F3H  = 3'b001;
    localparam logic [2:0] F3W  = 3'b010;
    localparam logic [2:0] F3BU = 3'b100;
    localparam logic [2:0] F3HU = 3'b101;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [AddrW-1:0]   idx_q;
    logic [1:0]         off_q;
    logic [31:0]        wdata_q;
    logic [2:0]         f3_q;
    logic               write_q;
    logic               err_q;
    logic               conflict_q;

    logic               req_one;
    logic               req_both;
    logic               accept;
    logic               access_bad;
    logic               commit;
    logic [3:0]         be;
    logic [31:0]        wlane;
    logic [31:0]        rword;
    logic [7:0]         rbyte;
    logic [15:0]        rhalf;
    logic [31:0]        load_data;

    logic [31:0]        mem [DEPTH_WORDS];

    // Upper address bits are deliberately dropped so accesses wrap.
    logic               unused_addr;
    assign unused_addr = ^iAddr[31:AddrW+2];

    assign req_one  = iMemRead ^ iMemWrite;
    assign req_both = iMemRead & iMemWrite;
    assign accept   = (state_q == StIdle) && req_one;
    assign commit   = (state_q == StDone) && write_q && !err_q;

    // Classify the incoming access: illegal size code or misaligned address.
    always_comb begin
        access_bad = 1'b0;
        case (iFunct3)
            F3B, F3BU: access_bad = 1'b0;
            F3H, F3HU: access_bad = iAddr[0];
            F3W:       access_bad = |iAddr[1:0];
            default:   access_bad = 1'b1;
        endcase
    end

    // State and wait counter register.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = StWait;
                        cnt_d   = WaitLoad;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Capture the request on acceptance; flag a read+write conflict for one cycle.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            idx_q      <= '0;
            off_q      <= 2'b00;
            wdata_q    <= 32'd0;
            f3_q       <= 3'b000;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= (state_q == StIdle) && req_both;
            if (accept) begin
                idx_q   <= iAddr[AddrW+1:2];
                off_q   <= iAddr[1:0];
                wdata_q <= iWData;
                f3_q    <= iFunct3;
                write_q <= iMemWrite;
                err_q   <= access_bad;
            end
        end
    end

    // Byte enables and lane-replicated store data.
    always_comb begin
        be    = 4'b1111;
        wlane = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                be    = 4'b0001 << off_q;
                wlane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be    = off_q[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata_q;
            end
        endcase
    end

    // Data store; not reset, stores commit on the edge leaving DONE.
    always_ff @(posedge iCLK) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx_q][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

    // Lane selection and sign/zero extension of load data.
    always_comb begin
        rword     = mem[idx_q];
        rbyte     = rword[{off_q, 3'b000} +: 8];
        rhalf     = off_q[1] ? rword[31:16] : rword[15:0];
        load_data = 32'd0;
        case (f3_q)
            F3B:     load_data = {{24{rbyte[7]}}, rbyte};
            F3BU:    load_data = {24'd0, rbyte};
            F3H:     load_data = {{16{rhalf[15]}}, rhalf};
            F3HU:    load_data = {16'd0, rhalf};
            F3W:     load_data = rword;
            default: load_data = 32'd0;
        endcase
    end

    // Outputs; stall is gated by reset so it drops immediately while in reset.
    always_comb begin
        oReady = (state_q == StDone);
        oErr   = ((state_q == StDone) && err_q) || conflict_q;
        oStall = iRSTn && (((state_q == StIdle) && req_one) || (state_q == StWait));
        oRData = 32'd0;
        if ((state_q == StDone) && !write_q && !err_q) begin
            oRData = load_data;
        end
    end

endmodule
